// File: rtl/twos_comp_serial_ctrl.sv
// twos_comp_serial_ctrl
// Sequencer for a bit-serial two's complement converter. A parallel word is
// latched on start. The converter is cleared for one cycle, and then the word
// is streamed LSB-first through it, one bit per clock. The converter's serial
// output is collected back into a parallel word. A one-cycle done pulse marks
// the moment data_out and ovf become valid.
module twos_comp_serial_ctrl #(
  parameter int MAX_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [MAX_W-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [MAX_W-1:0] data_out,
  output logic             conv_rst,
  output logic             conv_bit_in,
  input  logic             conv_bit_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MAX_W-1:0] W_ONE   = MAX_W'(1);

  state_t           state;
  logic [MAX_W-1:0] shift_reg;
  logic [MAX_W-1:0] capture;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_reg;
  logic             ovf_pend;

  logic [CNT_W-1:0] n_eff;
  logic [MAX_W-1:0] top_bit;
  logic [MAX_W-1:0] n_mask;
  logic             ovf_next;
  logic [CNT_W-1:0] idx;
  logic [MAX_W-1:0] capture_nxt;

  // Effective length and the most-negative-operand test, evaluated on the word being accepted
  always_comb begin
    n_eff    = (len == '0 || len > MAX_N) ? MAX_N : len;
    top_bit  = W_ONE << (n_eff - CNT_ONE);
    // For N == MAX_W the shifted bit falls off the top, and the mask wraps to all ones.
    n_mask   = (top_bit << 1) - W_ONE;
    ovf_next = ((data_in & n_mask) == top_bit);
  end

  // Place the converter's current output bit at its position in the result word
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    capture_nxt = capture;
    idx         = n_reg - cnt;
    for (int i = 0; i < MAX_W; i++) begin
      if (idx == CNT_W'(i)) capture_nxt[i] = conv_bit_out;
    end
  end

  // Sequencer FSM with registered busy/done/ovf/data_out
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      data_out  <= '0;
      shift_reg <= '0;
      capture   <= '0;
      cnt       <= '0;
      n_reg     <= '0;
      ovf_pend  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg <= data_in;
            cnt       <= n_eff;
            n_reg     <= n_eff;
            capture   <= '0;
            ovf_pend  <= ovf_next;
            data_out  <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          capture   <= capture_nxt;
          shift_reg <= shift_reg >> 1;
          cnt       <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            data_out <= capture_nxt;
            ovf      <= ovf_pend;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The converter is cleared whenever this block is reset, and during CLEAR. It is fed only in SHIFT.
  assign conv_rst    = rst | (state == S_CLEAR);
  assign conv_bit_in = (state == S_SHIFT) & shift_reg[0];

endmodule

// File: tb/tb_twos_comp_serial_ctrl.sv
// Testbench for twos_comp_serial_ctrl. It contains a behavioural model of the
// serial two's complement converter (pass bits through up to and including the
// first 1, invert after it). Directed words are checked against hand-computed results.
module tb_twos_comp_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  len;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] data_out;
  logic        conv_rst;
  logic        conv_bit_in;
  logic        conv_bit_out;
  logic        conv_seen;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  twos_comp_serial_ctrl #(.MAX_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf),
    .data_out     (data_out),
    .conv_rst     (conv_rst),
    .conv_bit_in  (conv_bit_in),
    .conv_bit_out (conv_bit_out)
  );

  // Serial converter model: Mealy output, state remembers whether a 1 has passed
  always @(posedge clk) begin
    if (conv_rst)         conv_seen <= 1'b0;
    else if (conv_bit_in) conv_seen <= 1'b1;
  end
  assign conv_bit_out = conv_bit_in ^ conv_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Launch one word and wait for done. cyc counts negedges after the start edge (1 = CLEAR cycle).
  task automatic run_word(input string tag, input logic [5:0] l, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_ovf, input int n,
                          input bit pulse_extra);
    int cyc;
    bit seen;
    @(negedge clk);
    len = l; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 6'd3; data_in = ~d;
    cyc = 1;
    check({tag, "_conv_rst_clear"}, 32'(conv_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (pulse_extra && cyc == 4) begin
        start = 1'b1; len = 6'd4; data_in = 32'h5;
      end else begin
        start = 1'b0;
      end
      if (conv_rst) check({tag, "_conv_rst_extra"}, 32'(conv_rst), 32'd0);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(n + 2));
    check({tag, "_data_out"}, data_out, exp_d);
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    if (pulse_extra) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_held"}, data_out, exp_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    rst = 1'b1; start = 1'b1; len = 6'd8; data_in = 32'h93;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_conv_rst", 32'(conv_rst), 32'd1);
    check("rst_conv_bit_in", 32'(conv_bit_in), 32'd0);
    rst = 1'b0; start = 1'b0;

    run_word("w93",     6'd8,  32'h0000_0093, 32'h0000_006D, 1'b0, 8,  1'b0);
    run_word("w30",     6'd8,  32'hABCD_0030, 32'h0000_00D0, 1'b0, 8,  1'b0);
    run_word("wFF",     6'd8,  32'h0000_00FF, 32'h0000_0001, 1'b0, 8,  1'b0);
    run_word("w00",     6'd8,  32'h0000_0000, 32'h0000_0000, 1'b0, 8,  1'b0);
    run_word("w80",     6'd8,  32'h0000_0080, 32'h0000_0080, 1'b1, 8,  1'b0);
    run_word("w6666",   6'd16, 32'h0000_6666, 32'h0000_999A, 1'b0, 16, 1'b0);
    run_word("wFFFF",   6'd16, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 16, 1'b0);
    run_word("wmin32",  6'd0,  32'h8000_0000, 32'h8000_0000, 1'b1, 32, 1'b0);
    run_word("w32",     6'd32, 32'h00EE_0F80, 32'hFF11_F080, 1'b0, 32, 1'b0);
    run_word("wlen40",  6'd40, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
    run_word("wn1_one", 6'd1,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1,  1'b0);
    run_word("wn1_zer", 6'd1,  32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1,  1'b0);
    run_word("wignore", 6'd8,  32'h0000_0030, 32'h0000_00D0, 1'b0, 8,  1'b1);
    run_word("wafter",  6'd8,  32'h0000_0093, 32'h0000_006D, 1'b0, 8,  1'b0);

    // Abort a 16-bit word with rst in its 5th SHIFT cycle (cycle 6 after the start edge)
    @(negedge clk);
    len = 6'd16; data_in = 32'h0000_1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_conv_rst", 32'(conv_rst), 32'd1);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    run_word("wpost", 6'd8, 32'h0000_0001, 32'h0000_00FF, 1'b0, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
